spi_flash_rd_seq: RTL and testbench
===================================

# spi_flash_rd_seq

APB3 master sequencer that drives the CoreSPI slave interface (master mode, Motorola mode 3, 8-bit frames) to perform SPI-flash READ transfers. A single start request reads `len` bytes from `addr` and delivers them on a valid/ready byte stream. The block sits directly upstream of the CoreSPI instance, owning its APB port, and removes per-byte CPU polling.

## Interface
- `SSEL_MASK`, default 8'h01: value written to the SSEL register to assert the flash chip select.
- `POLL_LIMIT`, default 1023: maximum STATUS polls per wait before aborting with an error.
- `PCLK` in, 1: clock; shared with CoreSPI.
- `PRESETN` in, 1: reset; asynchronous, active-low.
- `start` in, 1: one-cycle request; sampled only when `busy`=0.
- `addr` in, 24: flash byte address, latched on `start`.
- `len` in, 16: byte count, latched on `start`.
- `busy` out, 1: transfer in progress.
- `done` out, 1: one-cycle pulse at the end of a transfer.
- `err` out, 1: sticky; PSLVERR or poll timeout; cleared on the next accepted `start`.
- `m_data` out, 8: read byte.
- `m_valid` out, 1: `m_data` valid.
- `m_ready` in, 1: consumer accept.
- `PADDR` out, 7; `PSEL` out, 1; `PENABLE` out, 1; `PWRITE` out, 1; `PWDATA` out, 32: APB request to CoreSPI.
- `PRDATA` in, 32; `PREADY` in, 1; `PSLVERR` in, 1: APB response from CoreSPI.

## Operation
- CoreSPI register offsets: CTRL1 0x00, RXDATA 0x08, TXDATA 0x0C, STATUS 0x20, SSEL 0x24.
- STATUS bits: [2] rxempty, [3] txfull.
- States: IDLE -> CFG (write CTRL1=0x03, enable and master) -> CS_ON (write SSEL=`SSEL_MASK`) -> TXPOLL (read STATUS until txfull=0) -> TX (write TXDATA) -> RXPOLL (read STATUS until rxempty=0) -> RX (read RXDATA) -> back to TXPOLL, or to CS_OFF after the last frame.
- CS_OFF writes SSEL=0, then goes to DONE (`done` pulse) and IDLE.
- TX byte sequence: 0x03, addr[23:16], addr[15:8], addr[7:0], then `len` bytes of 0x00. Total frames = `len`+4.
- RX: the first 4 bytes are discarded. The rest load `m_data` and set `m_valid`.
- Lock-step: one TX frame per RX frame, so the CoreSPI FIFOs never hold more than one frame.
- Back-pressure: TXPOLL is not entered while `m_valid`=1 and `m_ready`=0.
- Frame counter is 17 bits and counts down. No wrap-around on `addr`; the flash's own wrap applies.
- Error: PSLVERR=1 on any access, or POLL_LIMIT polls without success -> `err`=1, jump to CS_OFF, then DONE. `done` still pulses.
- `start` with `len`=0 -> `done` one cycle later, no APB traffic.
- `start` while `busy`=1 is ignored.

## Timing
- APB access: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS (PENABLE=1) held until PREADY=1. PADDR, PWRITE and PWDATA are stable across both phases.
- PSEL drops for at least one cycle between accesses.
- PRDATA and PSLVERR are sampled in the cycle with PENABLE & PREADY.
- `busy` rises the cycle after `start` and falls with `done`.
- `m_valid` rises the cycle after RXDATA completes. It holds until `m_valid`&`m_ready`, then clears the next cycle unless reloaded.
- Reset values: all outputs 0.
- Reset mid-transfer returns the block to IDLE immediately. Chip select is recovered by CoreSPI's shared reset.

## Configuration
- `SPI_RD_SEQ_FAST_READ_EN` defined: opcode 0x0B with one dummy byte after the address; 5 leading RX bytes discarded; frames = `len`+5.
- Undefined: opcode 0x03, 4 discarded bytes.

## Test plan
- Reset -> PSEL, PENABLE, `busy`, `m_valid`, `err` all 0. Then `start`, `addr`=0x012345, `len`=4 with `m_ready`=1 -> TXDATA writes 03,01,23,45,00,00,00,00; 4 bytes out; SSEL written 0x01 then 0x00; one `done` pulse.
- `m_ready` held 0 for 50 cycles after the first byte -> no TXDATA write while stalled; no data lost; byte order preserved.
- `len`=0 -> `done` on cycle 2; PSEL never asserted.
- PSLVERR=1 on the 3rd TXDATA write -> `err`=1, SSEL written 0, `done` pulses. The next `start` clears `err`.
- STATUS txfull stuck at 1 with POLL_LIMIT=8 -> exactly 8 STATUS reads, then the error path.
- PREADY held low 3 cycles per access, then PRESETN asserted mid-transfer -> correct waited accesses before reset; all outputs 0 during reset; a new transfer completes normally afterwards.

Source files
------------

// File: rtl/spi_flash_rd_seq.sv
// rtl/spi_flash_rd_seq.sv - APB3 master sequencer driving CoreSPI for SPI-flash READ transfers
//
// Reads `len` bytes from flash address `addr` through a CoreSPI instance (master,
// mode 3, 8-bit frames) and delivers them on a valid/ready byte stream.
//
// Parameters:
//   SSEL_MASK   value written to CoreSPI SSEL to assert the flash chip select
//   POLL_LIMIT  STATUS polls allowed per wait before the transfer aborts with err
//
// Ports:
//   PCLK, PRESETN        clock (shared with CoreSPI), asynchronous active-low reset
//   start, addr, len     one-cycle request, flash byte address, byte count
//   busy, done, err      transfer in progress, end-of-transfer pulse, sticky error
//   m_data, m_valid,     read byte stream towards the consumer
//   m_ready
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA          APB request to CoreSPI
//   PRDATA, PREADY, PSLVERR                       APB response from CoreSPI
//
// Build option:
//   SPI_RD_SEQ_FAST_READ_EN  use FAST READ (0x0B) with one dummy byte after the address

module spi_flash_rd_seq #(
    parameter logic [7:0] SSEL_MASK  = 8'h01,
    parameter int         POLL_LIMIT = 1023
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [6:0]  PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

`ifdef SPI_RD_SEQ_FAST_READ_EN
    localparam logic [7:0] OPCODE  = 8'h0B;
    localparam logic [2:0] HDR_LEN = 3'd5;
`else
    localparam logic [7:0] OPCODE  = 8'h03;
    localparam logic [2:0] HDR_LEN = 3'd4;
`endif

    localparam logic [6:0] REG_CTRL1  = 7'h00;
    localparam logic [6:0] REG_RXDATA = 7'h08;
    localparam logic [6:0] REG_TXDATA = 7'h0C;
    localparam logic [6:0] REG_STATUS = 7'h20;
    localparam logic [6:0] REG_SSEL   = 7'h24;

    localparam int            PW        = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_CS_ON,
        S_TXPOLL,
        S_TX,
        S_RXPOLL,
        S_RX,
        S_CS_OFF,
        S_DONE
    } state_t;

    // Every access state walks GAP -> SETUP -> ACCESS; GAP keeps PSEL low
    // for a cycle between consecutive accesses.
    typedef enum logic [1:0] {
        PH_GAP,
        PH_SETUP,
        PH_ACCESS
    } phase_t;

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [23:0]   addr_q;
    logic [16:0]   frames_left;
    logic [2:0]    skip_left;
    logic [2:0]    tx_pos;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    tx_byte;

    logic accept;
    logic in_access;
    logic apb_done;
    logic poll_ok;
    logic poll_last;
    logic stalled;
    logic prdata_unused;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_access = (state != S_IDLE) && (state != S_DONE);
    assign apb_done  = in_access && (phase == PH_ACCESS) && PREADY;
    assign poll_ok   = (state == S_TXPOLL) ? ~PRDATA[3] : ~PRDATA[2];
    assign poll_last = (poll_cnt == POLL_LAST);
    assign stalled   = m_valid && !m_ready;
    assign busy      = in_access;
    assign done      = (state == S_DONE);
    assign prdata_unused = ^PRDATA[31:8];

    // Header bytes first; everything after the address (dummy and data
    // clocking frames) is 0x00.
    always_comb begin
        tx_byte = 8'h00;
        case (tx_pos)
            3'd0:    tx_byte = OPCODE;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state <= S_IDLE;
            phase <= PH_GAP;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        case (state)
            S_IDLE, S_DONE: begin
                phase_n = PH_GAP;
                if (accept)
                    state_n = (len == 16'd0) ? S_DONE : S_CFG;
                else
                    state_n = S_IDLE;
            end
            S_CFG, S_CS_ON, S_TXPOLL, S_TX, S_RXPOLL, S_RX, S_CS_OFF: begin
                case (phase)
                    PH_GAP: begin
                        // Hold off a new frame while an undelivered byte is pending,
                        // so RX can never overwrite m_data.
                        if (!((state == S_TXPOLL) && stalled))
                            phase_n = PH_SETUP;
                    end
                    PH_SETUP: phase_n = PH_ACCESS;
                    PH_ACCESS: begin
                        if (PREADY) begin
                            phase_n = PH_GAP;
                            if (PSLVERR) begin
                                state_n = (state == S_CS_OFF) ? S_DONE : S_CS_OFF;
                            end else begin
                                case (state)
                                    S_CFG:   state_n = S_CS_ON;
                                    S_CS_ON: state_n = S_TXPOLL;
                                    S_TXPOLL: begin
                                        if (poll_ok)        state_n = S_TX;
                                        else if (poll_last) state_n = S_CS_OFF;
                                    end
                                    S_TX: state_n = S_RXPOLL;
                                    S_RXPOLL: begin
                                        if (poll_ok)        state_n = S_RX;
                                        else if (poll_last) state_n = S_CS_OFF;
                                    end
                                    S_RX:    state_n = (frames_left == 17'd1) ? S_CS_OFF : S_TXPOLL;
                                    S_CS_OFF: state_n = S_DONE;
                                    default: state_n = S_IDLE;
                                endcase
                            end
                        end
                    end
                    default: phase_n = PH_GAP;
                endcase
            end
            default: begin
                state_n = S_IDLE;
                phase_n = PH_GAP;
            end
        endcase
    end

    // APB request decode: address/direction/data depend only on the state, so
    // they are stable across SETUP and ACCESS.
    always_comb begin
        PADDR   = 7'h00;
        PWRITE  = 1'b0;
        PWDATA  = 32'h0;
        PSEL    = in_access && (phase != PH_GAP);
        PENABLE = in_access && (phase == PH_ACCESS);
        case (state)
            S_CFG: begin
                PADDR  = REG_CTRL1;
                PWRITE = 1'b1;
                PWDATA = 32'h0000_0003;
            end
            S_CS_ON: begin
                PADDR  = REG_SSEL;
                PWRITE = 1'b1;
                PWDATA = {24'h0, SSEL_MASK};
            end
            S_TXPOLL, S_RXPOLL: PADDR = REG_STATUS;
            S_TX: begin
                PADDR  = REG_TXDATA;
                PWRITE = 1'b1;
                PWDATA = {24'h0, tx_byte};
            end
            S_RX: PADDR = REG_RXDATA;
            S_CS_OFF: begin
                PADDR  = REG_SSEL;
                PWRITE = 1'b1;
            end
            default: PADDR = 7'h00;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            addr_q      <= '0;
            frames_left <= '0;
            skip_left   <= '0;
            tx_pos      <= '0;
            poll_cnt    <= '0;
            err         <= 1'b0;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
        end else begin
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (accept) begin
                err         <= 1'b0;
                addr_q      <= addr;
                frames_left <= {1'b0, len} + 17'(HDR_LEN);
                skip_left   <= HDR_LEN;
                tx_pos      <= 3'd0;
                poll_cnt    <= '0;
            end else if (apb_done) begin
                if (PSLVERR) begin
                    err <= 1'b1;
                end else begin
                    case (state)
                        S_TXPOLL, S_RXPOLL: begin
                            if (poll_ok) begin
                                poll_cnt <= '0;
                            end else begin
                                poll_cnt <= poll_cnt + 1'b1;
                                if (poll_last)
                                    err <= 1'b1;
                            end
                        end
                        S_TX: begin
                            if (tx_pos < HDR_LEN)
                                tx_pos <= tx_pos + 3'd1;
                        end
                        S_RX: begin
                            frames_left <= frames_left - 17'd1;
                            // Bytes clocked in during opcode/address/dummy are junk.
                            if (skip_left != 3'd0) begin
                                skip_left <= skip_left - 3'd1;
                            end else begin
                                m_data  <= PRDATA[7:0];
                                m_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb/tb_spi_flash_rd_seq.sv - self-checking bench for spi_flash_rd_seq with a CoreSPI/flash model

module tb_spi_flash_rd_seq;

`ifdef SPI_RD_SEQ_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        PCLK;
    logic        PRESETN;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic [7:0]  m_data;
    logic        m_valid, m_ready;
    logic [6:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    spi_flash_rd_seq #(.SSEL_MASK(8'h01), .POLL_LIMIT(8)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .err(err), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];

    // CoreSPI + flash model state
    logic [7:0]  tx_log[$];
    logic [7:0]  ssel_log[$];
    logic [7:0]  ctrl_log[$];
    logic [7:0]  rx_q[$];
    int          status_reads = 0;
    int          psel_cycles  = 0;
    int          apb_viol     = 0;
    int          last_wait    = 0;
    int          wait_cfg     = 0;
    int          err_tx_n     = 0;
    logic        txfull_stuck = 1'b0;
    int          fidx = 0;
    int          wcnt = 0;
    bit          prev_done = 0;
    logic [23:0] faddr = 24'h0;
    logic [6:0]  s_addr;
    logic        s_wr;
    logic [31:0] s_wd;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] exp_tx(input int i, input logic [23:0] a);
        case (i)
            0:       return OPC;
            1:       return a[23:16];
            2:       return a[15:8];
            3:       return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge PCLK) begin
        if (!PRESETN) begin
            rx_q.delete();
            fidx = 0; wcnt = 0; prev_done = 0;
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        end else begin
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
            if (PSEL) psel_cycles++;
            if (prev_done && PSEL) apb_viol++;
            prev_done = 0;
            if (PENABLE && !PSEL) apb_viol++;
            if (PSEL && !PENABLE) begin
                s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA; wcnt = 0;
            end else if (PSEL && PENABLE) begin
                if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_wd) apb_viol++;
                if (wcnt < wait_cfg) begin
                    wcnt++;
                end else begin
                    PREADY = 1'b1; prev_done = 1; last_wait = wcnt;
                    if (PWRITE) begin
                        case (PADDR)
                            7'h00: ctrl_log.push_back(PWDATA[7:0]);
                            7'h24: begin
                                ssel_log.push_back(PWDATA[7:0]);
                                if (PWDATA[7:0] != 8'h00) begin fidx = 0; rx_q.delete(); end
                            end
                            7'h0C: begin
                                tx_log.push_back(PWDATA[7:0]);
                                if (err_tx_n != 0 && fidx + 1 == err_tx_n) begin
                                    PSLVERR = 1'b1;
                                end else begin
                                    if (fidx >= 1 && fidx <= 3) faddr = {faddr[15:0], PWDATA[7:0]};
                                    rx_q.push_back(fidx < HDR ? 8'hFF : flash_byte(faddr + 24'(fidx - HDR)));
                                    fidx++;
                                end
                            end
                            default: ;
                        endcase
                    end else if (PADDR == 7'h20) begin
                        status_reads++;
                        PRDATA = {28'h0, txfull_stuck, (rx_q.size() == 0), 2'b00};
                    end else if (PADDR == 7'h08 && rx_q.size() > 0) begin
                        PRDATA = {24'h0, rx_q.pop_front()};
                    end
                end
            end
        end
    end

    // One clock: the handshake is judged on the values that the next rising
    // edge will see, then the DUT is sampled at the falling edge.
    task automatic tick();
        logic       hs;
        logic [7:0] hd;
        logic [7:0] ev;
        hs = (m_valid === 1'b1) && (m_ready === 1'b1);
        hd = m_data;
        @(negedge PCLK);
        if (done === 1'b1) done_cnt++;
        if (hs) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_extra_byte: got %02h, expected no byte", hd);
            end else begin
                ev = sb.pop_front();
                if (hd !== ev) $display("FAIL sb_byte: got %02h, expected %02h", hd, ev);
                else n_pass++;
            end
        end
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] l, input bit expect_data);
        if (expect_data)
            for (int i = 0; i < int'(l); i++) sb.push_back(flash_byte(a + 24'(i)));
        addr = a; len = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin tick(); k++; end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s_done_timeout: no done after %0d cycles", tag, k);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_busy_at_done: got %b, expected 0", tag, busy);
        else n_pass++;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_bytes_missing: %0d left, expected 0", tag, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        PRESETN = 1'b0; start = 1'b0; addr = '0; len = '0; m_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({PSEL, PENABLE, busy, m_valid, err, done} !== 6'b0)
            $display("FAIL reset_flags: got PSEL/PENABLE/busy/m_valid/err/done=%b, expected 000000",
                     {PSEL, PENABLE, busy, m_valid, err, done});
        else n_pass++;
        n_checks++;
        if ({PADDR, PWRITE, PWDATA, m_data} !== '0)
            $display("FAIL reset_bus: got PADDR=%h PWRITE=%b PWDATA=%h m_data=%h, expected all 0",
                     PADDR, PWRITE, PWDATA, m_data);
        else n_pass++;
        PRESETN = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        int b_tx, b_ss, b_ct, b_dn;
        b_tx = tx_log.size(); b_ss = ssel_log.size(); b_ct = ctrl_log.size(); b_dn = done_cnt;
        m_ready = 1'b1;
        do_start(24'h012345, 16'd4, 1'b1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b, expected 1", busy);
        else n_pass++;
        wait_done("basic");
        drain("basic");
        n_checks++;
        if (tx_log.size() != b_tx + 4 + HDR)
            $display("FAIL basic_tx_count: got %0d, expected %0d", tx_log.size() - b_tx, 4 + HDR);
        else n_pass++;
        for (int i = 0; i < 4 + HDR && b_tx + i < tx_log.size(); i++) begin
            n_checks++;
            if (tx_log[b_tx + i] !== exp_tx(i, 24'h012345))
                $display("FAIL basic_tx_byte%0d: got %02h, expected %02h", i, tx_log[b_tx + i], exp_tx(i, 24'h012345));
            else n_pass++;
        end
        n_checks++;
        if (ssel_log.size() != b_ss + 2 || ssel_log[b_ss] !== 8'h01 || ssel_log[b_ss + 1] !== 8'h00)
            $display("FAIL basic_ssel: got %0d writes, expected 01 then 00", ssel_log.size() - b_ss);
        else n_pass++;
        n_checks++;
        if (ctrl_log.size() != b_ct + 1 || ctrl_log[b_ct] !== 8'h03)
            $display("FAIL basic_ctrl1: got %0d writes, expected one write of 03", ctrl_log.size() - b_ct);
        else n_pass++;
        n_checks++;
        if (done_cnt - b_dn != 1) $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - b_dn);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int b_tx, tx_at, k;
        b_tx = tx_log.size();
        m_ready = 1'b0;
        do_start(24'h100000, 16'd6, 1'b1);
        k = 0;
        while (m_valid !== 1'b1 && k < 2000) begin tick(); k++; end
        n_checks++;
        if (m_valid !== 1'b1) $display("FAIL bp_first_byte: got m_valid=%b, expected 1", m_valid);
        else n_pass++;
        tx_at = tx_log.size();
        repeat (50) tick();
        n_checks++;
        if (tx_log.size() != tx_at)
            $display("FAIL bp_tx_while_stalled: got %0d writes, expected 0", tx_log.size() - tx_at);
        else n_pass++;
        n_checks++;
        if (m_valid !== 1'b1) $display("FAIL bp_valid_held: got %b, expected 1", m_valid);
        else n_pass++;
        m_ready = 1'b1;
        wait_done("bp");
        drain("bp");
        n_checks++;
        if (tx_log.size() != b_tx + 6 + HDR)
            $display("FAIL bp_tx_count: got %0d, expected %0d", tx_log.size() - b_tx, 6 + HDR);
        else n_pass++;
    endtask

    task automatic test_len_zero();
        int b_ps;
        b_ps = psel_cycles;
        do_start(24'h000000, 16'd0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL len0_done: got done=%b busy=%b, expected done=1 busy=0", done, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL len0_done_pulse: got %b, expected 0", done);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (psel_cycles != b_ps) $display("FAIL len0_no_apb: got %0d PSEL cycles, expected 0", psel_cycles - b_ps);
        else n_pass++;
    endtask

    task automatic test_pslverr();
        int b_tx, b_dn;
        b_tx = tx_log.size(); b_dn = done_cnt;
        err_tx_n = 3;
        m_ready = 1'b1;
        do_start(24'hABCDEF, 16'd4, 1'b0);
        wait_done("slverr");
        n_checks++;
        if (err !== 1'b1) $display("FAIL slverr_err: got %b, expected 1", err);
        else n_pass++;
        n_checks++;
        if (tx_log.size() != b_tx + 3) $display("FAIL slverr_tx_count: got %0d, expected 3", tx_log.size() - b_tx);
        else n_pass++;
        n_checks++;
        if (ssel_log.size() == 0 || ssel_log[ssel_log.size() - 1] !== 8'h00)
            $display("FAIL slverr_cs_off: got last SSEL write missing or nonzero, expected 00");
        else n_pass++;
        n_checks++;
        if (done_cnt - b_dn != 1) $display("FAIL slverr_done: got %0d pulses, expected 1", done_cnt - b_dn);
        else n_pass++;
        tick();
        err_tx_n = 0;
        do_start(24'h000010, 16'd2, 1'b1);
        n_checks++;
        if (err !== 1'b0) $display("FAIL slverr_err_clear: got %b, expected 0", err);
        else n_pass++;
        wait_done("slverr_next");
        drain("slverr_next");
    endtask

    task automatic test_poll_timeout();
        int b_st, b_tx;
        b_st = status_reads; b_tx = tx_log.size();
        txfull_stuck = 1'b1;
        do_start(24'h000020, 16'd2, 1'b0);
        wait_done("poll");
        n_checks++;
        if (status_reads - b_st != 8) $display("FAIL poll_status_reads: got %0d, expected 8", status_reads - b_st);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL poll_err: got %b, expected 1", err);
        else n_pass++;
        n_checks++;
        if (tx_log.size() != b_tx) $display("FAIL poll_no_tx: got %0d writes, expected 0", tx_log.size() - b_tx);
        else n_pass++;
        n_checks++;
        if (ssel_log.size() == 0 || ssel_log[ssel_log.size() - 1] !== 8'h00)
            $display("FAIL poll_cs_off: got last SSEL write missing or nonzero, expected 00");
        else n_pass++;
        txfull_stuck = 1'b0;
        tick();
    endtask

    task automatic test_wait_reset();
        int b_tx, b_ss, k;
        wait_cfg = 3;
        m_ready = 1'b1;
        b_tx = tx_log.size();
        do_start(24'h00ABCD, 16'd8, 1'b1);
        k = 0;
        while (tx_log.size() < b_tx + HDR + 2 && k < 3000) begin tick(); k++; end
        n_checks++;
        if (tx_log.size() < b_tx + HDR + 2) $display("FAIL wr_progress: got %0d TX writes, expected >= %0d", tx_log.size() - b_tx, HDR + 2);
        else n_pass++;
        n_checks++;
        if (last_wait != 3) $display("FAIL wr_wait_states: got %0d, expected 3", last_wait);
        else n_pass++;
        #2 PRESETN = 1'b0;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, busy, done, err, m_valid} !== 6'b0 || {PADDR, PWRITE, PWDATA, m_data} !== '0)
            $display("FAIL wr_reset_outputs: got flags=%b PADDR=%h PWDATA=%h m_data=%h, expected all 0",
                     {PSEL, PENABLE, busy, done, err, m_valid}, PADDR, PWDATA, m_data);
        else n_pass++;
        sb.delete();
        repeat (2) tick();
        PRESETN = 1'b1;
        wait_cfg = 0;
        tick();
        b_tx = tx_log.size(); b_ss = ssel_log.size();
        do_start(24'h7FFFF0, 16'd3, 1'b1);
        wait_done("wr_after");
        drain("wr_after");
        for (int i = 0; i < 3 + HDR; i++) begin
            n_checks++;
            if (b_tx + i >= tx_log.size()) $display("FAIL wr_tx_byte%0d: got none, expected %02h", i, exp_tx(i, 24'h7FFFF0));
            else if (tx_log[b_tx + i] !== exp_tx(i, 24'h7FFFF0))
                $display("FAIL wr_tx_byte%0d: got %02h, expected %02h", i, tx_log[b_tx + i], exp_tx(i, 24'h7FFFF0));
            else n_pass++;
        end
        n_checks++;
        if (ssel_log.size() != b_ss + 2 || err !== 1'b0)
            $display("FAIL wr_after_status: got %0d SSEL writes err=%b, expected 2 and 0", ssel_log.size() - b_ss, err);
        else n_pass++;
    endtask

    task automatic test_apb_protocol();
        n_checks++;
        if (apb_viol != 0) $display("FAIL apb_protocol: got %0d violations, expected 0", apb_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_backpressure();
        test_len_zero();
        test_pslverr();
        test_poll_timeout();
        test_wait_reset();
        test_apb_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
